fetch_stage: RTL and testbench

//  Instruction-fetch stage; consumes the PC from the PC generator and returns stall/flush control to it.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0120;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small instruction FIFO with registered head outputs and a synchronous flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             head_valid_reg, head_valid_next;
  logic [WIDTH-1:0] head_data_reg, head_data_next;

  always_comb begin
    rd_ptr_next     = rd_ptr_reg + AW'(pop);
    wr_ptr_next     = wr_ptr_reg + AW'(push);
    count_next      = count_reg + CW'(push) - CW'(pop);
    head_valid_next = 1'b0;
    head_data_next  = '0;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (count_next != '0) begin
      head_valid_next = 1'b1;
      // The word written this edge becomes the head when the FIFO drains to it.
      if (push && (rd_ptr_next == wr_ptr_reg)) begin
        head_data_next = push_data;
      end else begin
        head_data_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
    end
  end

  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;
  assign count      = count_reg;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && !pop && !flush && (count_reg == CW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(pop && (count_reg == '0)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one imem read in flight, FIFO to decode, flush on taken branch.
// Optional stall-cycle counter enabled by defining FETCH_PERF_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  input  logic        isTakenBranch_i,
  output logic        halt_o,
  fetch_if.master     imem,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_reg, state_next;
  logic          drop_reg, drop_next;
  logic [31:0]   pend_pc_reg;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic          space;
  logic          req;
  logic          grant;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          head_valid;

  // A response that will be dropped does not need a FIFO slot reserved.
  assign occupancy = fifo_count + CW'((state_reg == WAIT) && !drop_reg);
  assign space     = occupancy < CW'(DEPTH);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      drop_reg    <= 1'b0;
      pend_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      drop_reg    <= drop_next;
      if (grant) begin
        pend_pc_reg <= pc_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    case (state_reg)
      IDLE: if (grant) state_next = WAIT;
      WAIT: if (imem.imem_rvalid_i && !grant) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if ((state_reg == WAIT) && imem.imem_rvalid_i) begin
      drop_next = 1'b0;
    end
    if (isTakenBranch_i && (state_reg == WAIT) && !imem.imem_rvalid_i) begin
      drop_next = 1'b1;
    end
  end

  always_comb begin
    req   = !reset_i && !isTakenBranch_i && space &&
            ((state_reg == IDLE) || imem.imem_rvalid_i);
    grant = req && imem.imem_gnt_i;
    push  = imem.imem_rvalid_i && (state_reg == WAIT) && !drop_reg && !isTakenBranch_i;
    pop   = head_valid && instr_ready_i;
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_i;
  assign halt_o           = !grant;

  assign push_entry = '{pc: pend_pc_reg, instr: imem.imem_rdata_i};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush      (isTakenBranch_i),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign instr_valid_o = head_valid;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_cnt_reg <= '0;
    end else if (!head_valid) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle tables with a PC-generator and imem model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] BR_TARGET = 32'h0000_0200;

  typedef struct {
    bit          rst_before;
    bit          br;
    bit          gnt;
    bit          rv;
    bit          rdy;
    bit          ereq;
    bit          ehalt;
    bit          evld;
    logic [31:0] eipc;
    logic [31:0] epc;
    string       tag;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        br;
  logic        halt;
  logic        ivld;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        rdy;
  logic [31:0] pend_q [$];
  vec_t        vecs [$];
  int          checks = 0;
  int          errors = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf;
`endif

  fetch_if imem_bus ();

  fetch_stage #(.DEPTH(2)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .pc_i            (pc),
    .isTakenBranch_i (br),
    .halt_o          (halt),
    .imem            (imem_bus.master),
    .instr_valid_o   (ivld),
    .instr_o         (instr),
    .instr_pc_o      (ipc),
    .instr_ready_i   (rdy)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt_o(perf)
`endif
  );

  always #5 clk = ~clk;

  // PC generator: advances only on a granted fetch, jumps to target after a branch.
  always @(posedge clk) begin
    if (reset)       pc <= RESET_PC;
    else if (br)     pc <= BR_TARGET;
    else if (!halt)  pc <= pc + 32'd4;
  end

  // imem: remembers granted addresses, answers in order when the table asserts rvalid.
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
    end else begin
      if (imem_bus.imem_rvalid_i && pend_q.size() != 0) void'(pend_q.pop_front());
      if (imem_bus.imem_req_o && imem_bus.imem_gnt_i) pend_q.push_back(imem_bus.imem_addr_o);
    end
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit r, input bit b, input bit g, input bit v, input bit y,
                              input bit q, input bit h, input bit l,
                              input logic [31:0] ip, input logic [31:0] p, input string t);
    vec_t x;
    x.rst_before = r; x.br = b; x.gnt = g; x.rv = v; x.rdy = y;
    x.ereq = q; x.ehalt = h; x.evld = l; x.eipc = ip; x.epc = p; x.tag = t;
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    br    = 1'b0;
    rdy   = 1'b0;
    imem_bus.imem_gnt_i    = 1'b1;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = '0;
    @(negedge clk);
    check("rst.req",   32'(imem_bus.imem_req_o), 32'd0);
    check("rst.halt",  32'(halt), 32'd1);
    check("rst.vld",   32'(ivld), 32'd0);
    check("rst.instr", instr, 32'd0);
    check("rst.ipc",   ipc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // rst, br, gnt, rv, rdy | req, halt, vld, instr_pc, pc_i
    vecs.push_back(mk(1,0,1,0,1, 1,0,0, 32'h000, 32'h120, "t1"));
    vecs.push_back(mk(0,0,1,1,1, 1,0,0, 32'h000, 32'h124, "t1"));
    vecs.push_back(mk(0,0,1,1,1, 0,1,1, 32'h120, 32'h128, "t1"));
    vecs.push_back(mk(0,0,1,0,1, 1,0,1, 32'h124, 32'h128, "t1"));
    vecs.push_back(mk(0,0,1,1,1, 1,0,0, 32'h000, 32'h12c, "t1"));
    vecs.push_back(mk(0,0,1,1,1, 0,1,1, 32'h128, 32'h130, "t1"));
    vecs.push_back(mk(0,0,1,0,1, 1,0,1, 32'h12c, 32'h130, "t1"));
    // full FIFO with decode stalled
    vecs.push_back(mk(1,0,1,0,0, 1,0,0, 32'h000, 32'h120, "t2"));
    vecs.push_back(mk(0,0,1,1,0, 1,0,0, 32'h000, 32'h124, "t2"));
    vecs.push_back(mk(0,0,1,1,0, 0,1,1, 32'h120, 32'h128, "t2"));
    vecs.push_back(mk(0,0,1,0,0, 0,1,1, 32'h120, 32'h128, "t2"));
    vecs.push_back(mk(0,0,1,0,1, 0,1,1, 32'h120, 32'h128, "t2"));
    vecs.push_back(mk(0,0,1,0,0, 1,0,1, 32'h124, 32'h128, "t2"));
    vecs.push_back(mk(0,0,0,0,0, 0,1,1, 32'h124, 32'h12c, "t2"));
    // grant withheld for five cycles
    vecs.push_back(mk(1,0,0,0,1, 1,1,0, 32'h000, 32'h120, "t3"));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,1, 1,1,0, 32'h000, 32'h120, "t3"));
    vecs.push_back(mk(0,0,1,0,1, 1,0,0, 32'h000, 32'h120, "t3"));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0, 32'h000, 32'h124, "t3"));
    // flush while waiting; stale response arrives two cycles later
    vecs.push_back(mk(1,0,1,0,0, 1,0,0, 32'h000, 32'h120, "t4"));
    vecs.push_back(mk(0,0,1,1,0, 1,0,0, 32'h000, 32'h124, "t4"));
    vecs.push_back(mk(0,1,1,0,0, 0,1,1, 32'h120, 32'h128, "t4"));
    vecs.push_back(mk(0,0,1,0,0, 0,1,0, 32'h000, 32'h200, "t4"));
    vecs.push_back(mk(0,0,1,1,0, 1,0,0, 32'h000, 32'h200, "t4"));
    vecs.push_back(mk(0,0,0,1,1, 1,1,0, 32'h000, 32'h204, "t4"));
    vecs.push_back(mk(0,0,0,0,1, 1,1,1, 32'h200, 32'h204, "t4"));
    // flush coinciding with rvalid and pop
    vecs.push_back(mk(1,0,1,0,0, 1,0,0, 32'h000, 32'h120, "t5"));
    vecs.push_back(mk(0,0,1,1,0, 1,0,0, 32'h000, 32'h124, "t5"));
    vecs.push_back(mk(0,1,1,1,1, 0,1,1, 32'h120, 32'h128, "t5"));
    vecs.push_back(mk(0,0,1,0,1, 1,0,0, 32'h000, 32'h200, "t5"));
    vecs.push_back(mk(0,0,0,1,1, 1,1,0, 32'h000, 32'h204, "t5"));
    vecs.push_back(mk(0,0,0,0,1, 1,1,1, 32'h200, 32'h204, "t5"));

    reset = 1'b1;
    br    = 1'b0;
    rdy   = 1'b0;
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = '0;

    foreach (vecs[i]) begin
      vec_t v;
      string n;
      v = vecs[i];
      if (v.rst_before) do_reset();
      br  = v.br;
      rdy = v.rdy;
      imem_bus.imem_gnt_i    = v.gnt;
      imem_bus.imem_rvalid_i = v.rv;
      imem_bus.imem_rdata_i  = (v.rv && pend_q.size() != 0) ? word_of(pend_q[0]) : 32'h0;
      #1;
      n = $sformatf("%s[%0d]", v.tag, i);
      check({n, ".req"},  32'(imem_bus.imem_req_o), 32'(v.ereq));
      check({n, ".halt"}, 32'(halt), 32'(v.ehalt));
      check({n, ".vld"},  32'(ivld), 32'(v.evld));
      check({n, ".pc"},   pc, v.epc);
      check({n, ".addr"}, imem_bus.imem_addr_o, v.epc);
      if (v.evld) begin
        check({n, ".ipc"},   ipc, v.eipc);
        check({n, ".instr"}, instr, word_of(v.eipc));
      end
      $display("vec %s br=%0d gnt=%0d rv=%0d rdy=%0d -> req=%0d halt=%0d vld=%0d ipc=%h pc=%h",
               n, v.br, v.gnt, v.rv, v.rdy, imem_bus.imem_req_o, halt, ivld, ipc, pc);
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    do_reset();
    imem_bus.imem_gnt_i = 1'b0;
    repeat (3) @(negedge clk);
    check("perf.after3", perf, 32'd3);
    $display("perf stall count after 3 idle cycles = %0d", perf);
    reset = 1'b1;
    @(negedge clk);
    check("perf.reset", perf, 32'd0);
    $display("perf stall count after reset = %0d", perf);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
